// File: rtl/d_seq.sv
// d_seq -- secure-block transaction sequencer around the D-line driver.
//
// Receives a block through the driver after a write command, hands it to the
// cipher engine, holds the processed block until a read command, sends it back
// through the driver and returns to idle. CRC failures and stalled transfers
// abort the transaction by pulsing the driver reset for two cycles.
//
// Optional build macro: DSEQ_ERRCNT_EN adds oerr_cnt, a saturating count of
// aborts (cleared only by reset).
//
// Ports:
//   iclk, irst_n                 SD clock, asynchronous active-low reset
//   iwrite_cmd, iread_cmd        one-cycle command pulses from the command layer
//   odrv_start, odrv_rst         driver start pulse / driver reset (abort)
//   idrv_done, idrv_crc_fail     driver completion / CRC failure
//   oproc_start, iproc_done      cipher start pulse / cipher done pulse
//   obusy, odata_ready           transaction in progress / block held for read
//   oerr_crc, oerr_timeout       sticky error flags, cleared by accepted write
//   owr_rej                      pulse: write command ignored (not idle)
//   oerr_cnt [7:0]               abort count (DSEQ_ERRCNT_EN only)

module d_seq #(
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       iwrite_cmd,
  input  logic       iread_cmd,
  output logic       odrv_start,
  output logic       odrv_rst,
  input  logic       idrv_done,
  input  logic       idrv_crc_fail,
  output logic       oproc_start,
  input  logic       iproc_done,
  output logic       obusy,
  output logic       odata_ready,
  output logic       oerr_crc,
  output logic       oerr_timeout,
  output logic       owr_rej
`ifdef DSEQ_ERRCNT_EN
  ,
  output logic [7:0] oerr_cnt
`endif
);

  // ABORT is split into two states so the driver reset lasts exactly two
  // cycles without borrowing the watchdog.
  typedef enum logic [3:0] {
    S_IDLE,
    S_RCV_START,
    S_RCV_WAIT,
    S_PROC_START,
    S_PROC_WAIT,
    S_READY,
    S_SEND_START,
    S_SEND_WAIT,
    S_ABORT,
    S_ABORT2
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT - 1);
  // The driver clears its stale CRC flag one cycle after start, so the flag
  // is only trusted from the third RCV_WAIT cycle on.
  localparam logic [CNT_W-1:0] CRC_SKIP = CNT_W'(2);

  state_t           state, state_nx;
  logic [CNT_W-1:0] wd;
  logic             rd_pend;
  logic             set_crc, set_to, clr_err, clr_pend;

  always_comb begin
    state_nx = state;
    set_crc  = 1'b0;
    set_to   = 1'b0;
    clr_err  = 1'b0;
    clr_pend = 1'b0;
    case (state)
      S_IDLE: begin
        if (iwrite_cmd) begin
          state_nx = S_RCV_START;
          clr_err  = 1'b1;
        end
      end
      S_RCV_START:  state_nx = S_RCV_WAIT;
      S_RCV_WAIT: begin
        if (idrv_done) begin
          state_nx = S_PROC_START;
        end else if (idrv_crc_fail && (wd >= CRC_SKIP)) begin
          state_nx = S_ABORT;
          set_crc  = 1'b1;
        end else if (wd == WD_LAST) begin
          state_nx = S_ABORT;
          set_to   = 1'b1;
        end
      end
      S_PROC_START: state_nx = S_PROC_WAIT;
      S_PROC_WAIT: begin
        if (iproc_done) state_nx = S_READY;
      end
      S_READY: begin
        if (iread_cmd || rd_pend) begin
          state_nx = S_SEND_START;
          clr_pend = 1'b1;
        end
      end
      S_SEND_START: state_nx = S_SEND_WAIT;
      S_SEND_WAIT: begin
        if (idrv_done) begin
          state_nx = S_IDLE;
        end else if (wd == WD_LAST) begin
          state_nx = S_ABORT;
          set_to   = 1'b1;
        end
      end
      S_ABORT:  state_nx = S_ABORT2;
      S_ABORT2: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with the
  // cycle its state is occupied.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state        <= S_IDLE;
      wd           <= '0;
      rd_pend      <= 1'b0;
      odrv_start   <= 1'b0;
      odrv_rst     <= 1'b0;
      oproc_start  <= 1'b0;
      obusy        <= 1'b0;
      odata_ready  <= 1'b0;
      oerr_crc     <= 1'b0;
      oerr_timeout <= 1'b0;
      owr_rej      <= 1'b0;
    end else begin
      state <= state_nx;

      if (state_nx != state)
        wd <= '0;
      else if (((state == S_RCV_WAIT) || (state == S_SEND_WAIT)) && (wd != '1))
        wd <= wd + CNT_W'(1);

      if (clr_pend)
        rd_pend <= 1'b0;
      else if (iread_cmd && ((state == S_PROC_START) || (state == S_PROC_WAIT)))
        rd_pend <= 1'b1;

      odrv_start  <= (state_nx == S_RCV_START) || (state_nx == S_SEND_START);
      odrv_rst    <= (state_nx == S_ABORT) || (state_nx == S_ABORT2);
      oproc_start <= (state_nx == S_PROC_START);
      obusy       <= (state_nx != S_IDLE);
      odata_ready <= (state_nx == S_READY);
      owr_rej     <= iwrite_cmd && (state != S_IDLE);

      if (clr_err)
        oerr_crc <= 1'b0;
      else if (set_crc)
        oerr_crc <= 1'b1;

      if (clr_err)
        oerr_timeout <= 1'b0;
      else if (set_to)
        oerr_timeout <= 1'b1;
    end
  end

`ifdef DSEQ_ERRCNT_EN
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n)
      oerr_cnt <= '0;
    else if ((state_nx == S_ABORT) && (state != S_ABORT) && (oerr_cnt != '1))
      oerr_cnt <= oerr_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_d_seq.sv
// tb_d_seq -- bench for d_seq (TIMEOUT=100). Each cycle the bench predicts
// every output from a phase/elapsed-time model of the transaction rules and
// compares after the clock edge. Directed scenarios cover the main flows and
// corner cases; a randomized phase follows.

module tb_d_seq;

  localparam int unsigned TO = 100;

  logic iclk = 1'b0;
  logic irst_n = 1'b1;
  logic iwrite_cmd = 1'b0, iread_cmd = 1'b0, idrv_done = 1'b0;
  logic idrv_crc_fail = 1'b0, iproc_done = 1'b0;
  logic odrv_start, odrv_rst, oproc_start, obusy, odata_ready;
  logic oerr_crc, oerr_timeout, owr_rej;
`ifdef DSEQ_ERRCNT_EN
  logic [7:0] oerr_cnt;
`endif

  d_seq #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .iclk          (iclk),
    .irst_n        (irst_n),
    .iwrite_cmd    (iwrite_cmd),
    .iread_cmd     (iread_cmd),
    .odrv_start    (odrv_start),
    .odrv_rst      (odrv_rst),
    .idrv_done     (idrv_done),
    .idrv_crc_fail (idrv_crc_fail),
    .oproc_start   (oproc_start),
    .iproc_done    (iproc_done),
    .obusy         (obusy),
    .odata_ready   (odata_ready),
    .oerr_crc      (oerr_crc),
    .oerr_timeout  (oerr_timeout),
    .owr_rej       (owr_rej)
`ifdef DSEQ_ERRCNT_EN
    ,
    .oerr_cnt      (oerr_cnt)
`endif
  );

  always #5 iclk = ~iclk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction phases of the reference model; t counts cycles spent in the
  // current phase.
  typedef enum int {M_IDLE, M_RX_GO, M_RX, M_CIPH_GO, M_CIPH, M_HOLD,
                    M_TX_GO, M_TX, M_RECOVER} mphase_t;

  mphase_t ph = M_IDLE;
  int      t = 0;
  bit      pend = 0, m_crc = 0, m_to = 0, m_rej = 0;
  int      m_cnt = 0;

  task automatic model_reset();
    ph = M_IDLE; t = 0; pend = 0; m_crc = 0; m_to = 0; m_rej = 0; m_cnt = 0;
  endtask

  task automatic model_edge(bit w, bit r, bit d, bit c, bit p);
    mphase_t nph;
    nph   = ph;
    m_rej = w && (ph != M_IDLE);
    case (ph)
      M_IDLE:    if (w) begin nph = M_RX_GO; m_crc = 0; m_to = 0; end
      M_RX_GO:   nph = M_RX;
      M_RX: begin
        if (d)                      nph = M_CIPH_GO;
        else if (c && t >= 2)       begin nph = M_RECOVER; m_crc = 1; end
        else if (t == int'(TO) - 1) begin nph = M_RECOVER; m_to = 1; end
      end
      M_CIPH_GO: nph = M_CIPH;
      M_CIPH:    if (p) nph = M_HOLD;
      M_HOLD:    if (r || pend) begin nph = M_TX_GO; pend = 0; end
      M_TX_GO:   nph = M_TX;
      M_TX: begin
        if (d)                      nph = M_IDLE;
        else if (t == int'(TO) - 1) begin nph = M_RECOVER; m_to = 1; end
      end
      M_RECOVER: if (t == 1) nph = M_IDLE;
      default:   nph = M_IDLE;
    endcase
    if (r && (ph == M_CIPH_GO || ph == M_CIPH)) pend = 1;
    if (nph == M_RECOVER && ph != M_RECOVER && m_cnt < 255) m_cnt++;
    t  = (nph != ph) ? 0 : t + 1;
    ph = nph;
  endtask

  task automatic check_outputs();
    check("odrv_start",   32'(odrv_start),   32'(ph == M_RX_GO || ph == M_TX_GO));
    check("odrv_rst",     32'(odrv_rst),     32'(ph == M_RECOVER));
    check("oproc_start",  32'(oproc_start),  32'(ph == M_CIPH_GO));
    check("obusy",        32'(obusy),        32'(ph != M_IDLE));
    check("odata_ready",  32'(odata_ready),  32'(ph == M_HOLD));
    check("oerr_crc",     32'(oerr_crc),     32'(m_crc));
    check("oerr_timeout", 32'(oerr_timeout), 32'(m_to));
    check("owr_rej",      32'(owr_rej),      32'(m_rej));
`ifdef DSEQ_ERRCNT_EN
    check("oerr_cnt",     32'(oerr_cnt),     32'(m_cnt));
`endif
  endtask

  // Drive inputs (called just after a falling edge), clock once, update the
  // model, compare, then return on the next falling edge.
  task automatic cycle(bit w = 0, bit r = 0, bit d = 0, bit c = 0, bit p = 0);
    iwrite_cmd = w; iread_cmd = r; idrv_done = d; idrv_crc_fail = c; iproc_done = p;
    @(posedge iclk);
    model_edge(w, r, d, c, p);
    #1 check_outputs();
    @(negedge iclk);
  endtask

  initial begin
    int n;

    // Reset
    #3 irst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge iclk);
    check_outputs();
    irst_n = 1'b1;

    // Nominal flow: done at RCV_WAIT cycle 20
    cycle(.w(1));
    check("nom_start", 32'(odrv_start), 32'd1);
    cycle();
    repeat (20) cycle();
    cycle(.d(1));
    check("nom_proc_start", 32'(oproc_start), 32'd1);
    repeat (3) cycle();
    cycle(.p(1));
    check("nom_ready", 32'(odata_ready), 32'd1);
    cycle();
    cycle(.r(1));
    check("nom_send_start", 32'(odrv_start), 32'd1);
    repeat (4) cycle();
    cycle(.d(1));
    check("nom_idle", 32'({obusy, oerr_crc, oerr_timeout}), 32'd0);
    cycle();

    // CRC fail: stale flag through RCV_WAIT cycles 0-1, real one at cycle 5
    cycle(.w(1), .c(1));
    cycle(.c(1));
    cycle(.c(1));
    cycle(.c(1));
    check("crc_no_early_abort", 32'(odrv_rst), 32'd0);
    repeat (3) cycle();
    cycle(.c(1));
    check("crc_abort", 32'({odrv_rst, oerr_crc}), 32'd3);
    cycle();
    check("crc_rst_2nd", 32'(odrv_rst), 32'd1);
    cycle();
    check("crc_back_idle", 32'({odrv_rst, obusy}), 32'd0);
    cycle();

    // Receive timeout: odrv_rst 100 cycles after RCV_WAIT entry
    cycle(.w(1));
    n = 0;
    while (odrv_rst !== 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    check("to_latency", 32'(n), 32'(TO + 1));
    check("to_flag", 32'(oerr_timeout), 32'd1);
    repeat (3) cycle();
    check("to_sticky_idle", 32'(oerr_timeout), 32'd1);
    cycle(.w(1));
    check("to_cleared", 32'(oerr_timeout), 32'd0);

    // Early read during PROC_WAIT (write still in RCV_START here)
    cycle();
    repeat (5) cycle();
    cycle(.d(1));
    cycle();
    cycle(.r(1));
    cycle();
    cycle(.p(1));
    check("early_ready", 32'(odata_ready), 32'd1);
    cycle();
    check("early_send", 32'(odrv_start), 32'd1);
    cycle();
    // Write rejected during SEND_WAIT
    cycle(.w(1));
    check("rej_pulse", 32'({owr_rej, obusy}), 32'd3);
    cycle();
    check("rej_once", 32'(owr_rej), 32'd0);
    cycle(.d(1));
    check("send_done", 32'(obusy), 32'd0);

    // Write and read together in IDLE; done coincides with watchdog expiry
    cycle(.w(1), .r(1));
    check("wr_priority", 32'(odrv_start), 32'd1);
    cycle();
    repeat (TO - 1) cycle();
    cycle(.d(1));
    check("done_beats_to", 32'({oproc_start, odrv_rst, oerr_timeout}), 32'd4);
    cycle();
    cycle(.p(1));
    cycle(.r(1));
    cycle();
    cycle(.d(1));

    // Asynchronous reset mid-RCV_WAIT
    cycle(.w(1));
    repeat (6) cycle();
    #2 irst_n = 1'b0;
    model_reset();
    #1 check("rst_async", 32'({odrv_start, odrv_rst, oproc_start, obusy, odata_ready,
                               oerr_crc, oerr_timeout, owr_rej}), 32'd0);
    check_outputs();
    @(negedge iclk);
    irst_n = 1'b1;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cycle(.w($urandom_range(7) == 0), .r($urandom_range(9) == 0),
            .d($urandom_range(49) == 0), .c($urandom_range(39) == 0),
            .p($urandom_range(7) == 0));
    end
    // Return to IDLE deterministically before the abort burst
    n = 0;
    while (ph != M_IDLE && n < 300) begin
      cycle(.r(1), .d(1), .p(1));
      n++;
    end
    check("rand_drain", 32'(obusy), 32'd0);

    // Abort burst: pushes the abort count well past saturation
    for (int k = 0; k < 300; k++) begin
      cycle(.w(1));
      cycle();
      cycle();
      cycle();
      cycle(.c(1));
      cycle();
      cycle();
    end
`ifdef DSEQ_ERRCNT_EN
    check("errcnt_sat", 32'(oerr_cnt), 32'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_seq.md
Name: d_seq

Overview:
- Sequences one secure-block transaction around the D-line driver:
  - start the driver to receive a block after a write command;
  - hand the received RAM contents to the cipher engine;
  - hold the processed block until a read command arrives;
  - restart the driver to send the block, then report the result.
- Recovers from CRC failures and stalled transfers by pulsing the driver reset.
- Sits between the command-line layer, the D-line driver and the cipher core.

Parameters:
- TIMEOUT, 65535, SD clock cycles allowed in RCV_WAIT or SEND_WAIT before abort (must be ≥ 4).
- CNT_W, 16, width of the watchdog counter (≥ $clog2(TIMEOUT+1)).

Ports:
- iclk  input  1  SD clock
- irst_n  input  1  asynchronous active-low reset
- iwrite_cmd  input  1  one-cycle pulse: write-block command accepted
- iread_cmd  input  1  one-cycle pulse: read-block command accepted
- odrv_start  output  1  one-cycle pulse to driver istart
- odrv_rst  output  1  active-high driver reset (abort)
- idrv_done  input  1  driver odone
- idrv_crc_fail  input  1  driver ocrc_fail
- oproc_start  output  1  one-cycle pulse to cipher start
- iproc_done  input  1  cipher done pulse
- obusy  output  1  transaction in progress (state ≠ IDLE)
- odata_ready  output  1  processed block held, awaiting read
- oerr_crc  output  1  sticky: last receive failed CRC
- oerr_timeout  output  1  sticky: last transfer timed out
- owr_rej  output  1  one-cycle pulse: iwrite_cmd ignored (not IDLE)

Behaviour:
- Reset: state IDLE; all outputs 0; watchdog 0; read-pending flag 0. Reset is asynchronous and takes effect mid-transaction with no further outputs.
- All outputs are registered; pulses last exactly one cycle.
- States:
  - IDLE: on iwrite_cmd → RCV_START; clears oerr_crc and oerr_timeout.
  - RCV_START: odrv_start=1 for this cycle only; → RCV_WAIT.
  - RCV_WAIT:
    - idrv_done → PROC_START.
    - Otherwise idrv_crc_fail → ABORT and set oerr_crc. idrv_crc_fail is ignored in the first two cycles of RCV_WAIT, because the driver clears its stale flag one cycle after start.
    - Otherwise watchdog == TIMEOUT−1 → ABORT and set oerr_timeout.
    - idrv_done wins over the other two conditions in the same cycle.
  - PROC_START: oproc_start=1; → PROC_WAIT.
  - PROC_WAIT: iproc_done → READY. No timeout in this state.
  - READY: odata_ready=1. On iread_cmd, or with read-pending set on entry, → SEND_START and clear read-pending.
  - SEND_START: odrv_start=1; → SEND_WAIT.
  - SEND_WAIT: idrv_done → IDLE; watchdog expiry → ABORT and set oerr_timeout.
  - ABORT: odrv_rst=1 for exactly 2 cycles; → IDLE.
- Watchdog:
  - Clears on every state entry.
  - Increments each cycle in RCV_WAIT and SEND_WAIT.
  - Saturates; it never wraps.
- iread_cmd:
  - In PROC_START or PROC_WAIT, it sets read-pending.
  - In IDLE, RCV_*, SEND_* or ABORT, it is ignored.
- iwrite_cmd:
  - In any state other than IDLE, it is ignored and owr_rej pulses the next cycle.
  - In IDLE with iread_cmd in the same cycle, the write is taken and the read is ignored.
- Sticky errors hold through IDLE until the next accepted iwrite_cmd clears them, in the same edge as the IDLE→RCV_START transition.

Optional Feature:
- Macro: DSEQ_ERRCNT_EN.
- Defined:
  - Adds output oerr_cnt [7:0], reset 0.
  - Increments by 1 on each entry to ABORT and saturates at 8'hFF.
  - Cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Nominal flow, TIMEOUT=100:
  - iwrite_cmd → odrv_start one cycle later;
  - idrv_done at cycle 20 → oproc_start next cycle;
  - iproc_done → odata_ready=1;
  - iread_cmd → odrv_start;
  - idrv_done → obusy=0 and both error flags 0.
- CRC fail: idrv_crc_fail=1 held from before start; assert it again at RCV_WAIT cycle 5 → no abort in cycles 0–1; abort at cycle 5 with oerr_crc=1, odrv_rst high exactly 2 cycles, then IDLE.
- Receive timeout: TIMEOUT=100, no idrv_done → odrv_rst asserts 100 cycles after RCV_WAIT entry and oerr_timeout=1; the next iwrite_cmd clears the flag.
- Early read: iread_cmd during PROC_WAIT, then iproc_done → odrv_start for send in the cycle after READY entry, with no further iread_cmd needed.
- Rejection and priority:
  - iwrite_cmd during SEND_WAIT → owr_rej pulse and state unchanged;
  - iwrite_cmd and iread_cmd together in IDLE → RCV_START;
  - idrv_done and watchdog expiry in the same cycle → success.
- Reset and counter: irst_n low mid-RCV_WAIT → all outputs 0 immediately. With DSEQ_ERRCNT_EN defined, 3 aborts give oerr_cnt=3, and 300 aborts give 8'hFF.
